// File: rtl/fineps_pkg.sv
// fineps_pkg
// Shared definitions for the fine phase-shift step sequencer:
//   - fineps_state_e           : sequencer FSM states
//   - FINEPS_STEPS_PER_VCO     : PS steps per VCO period
//   - fineps_steps_per_period  : steps per output period for a given VCO multiply
//   - fineps_shortest_path     : modular distance plus direction for absolute moves
package fineps_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CALC   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } fineps_state_e;

   localparam int FINEPS_STEPS_PER_VCO = 56;

   typedef struct packed {
      logic        inc;    // 1 = increment, 0 = decrement
      logic [31:0] count;  // number of steps to take
   } fineps_path_t;

   function automatic int fineps_steps_per_period(input int vco_mult);
      return FINEPS_STEPS_PER_VCO * vco_mult;
   endfunction

   // Shortest way round the phase circle from position to target.
   // Both inputs must already be in 0..period-1. Exactly half a period
   // resolves to increment.
   function automatic fineps_path_t fineps_shortest_path(
      input int unsigned target,
      input int unsigned position,
      input int unsigned period
   );
      int unsigned  d;
      fineps_path_t p;
      d = (target >= position) ? (target - position) : (target + period - position);
      if (d <= (period / 2)) begin
         p.inc   = 1'b1;
         p.count = d;
      end else begin
         p.inc   = 1'b0;
         p.count = period - d;
      end
      return p;
   endfunction

endpackage

// File: rtl/fineps_psdone_watchdog.sv
// fineps_psdone_watchdog
// Counts enabled cycles since the last clear and flags expiry on the
// TIMEOUT_CYCLES-th enabled cycle without a clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (one PS step just issued)
//   en         : count this cycle (waiting for PSDONE)
//   expired    : high while enabled on the final allowed wait cycle
module fineps_psdone_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Saturates at LAST so a stalled enable cannot wrap back to a safe value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/fineps_step_sequencer.sv
// fineps_step_sequencer
// Turns relative (signed step count) or absolute (target position) phase
// commands into paced MMCM PSEN pulses, one step outstanding at a time, and
// tracks the phase position modulo one output period.
// Ports:
//   in_clk, in_rst_n   : PS clock, asynchronous active-low reset
//   in_locked          : MMCM locked; low forces IDLE and position 0
//   in_cmd_valid/out_cmd_ready, in_cmd_abs, in_cmd_value : command channel
//   out_psen, out_psincdec, in_psdone : MMCM dynamic phase-shift port
//   out_position       : current phase, 0..STEPS_PER_PERIOD-1
//   out_busy, out_done : command in progress / one-cycle completion pulse
//   out_timeout        : sticky PSDONE watchdog flag, cleared on accept
//   out_state          : FSM state (fineps_state_e encoding) for observation
module fineps_step_sequencer
   import fineps_pkg::*;
#(
   parameter int STEP_WIDTH       = 12,
   parameter int STEPS_PER_PERIOD = fineps_steps_per_period(9),  // >= 4, even
   parameter int POS_WIDTH        = 9,   // 2**POS_WIDTH >= STEPS_PER_PERIOD
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic                  in_locked,
   input  logic                  in_cmd_valid,
   output logic                  out_cmd_ready,
   input  logic                  in_cmd_abs,
   input  logic [STEP_WIDTH-1:0] in_cmd_value,
   output logic                  out_psen,
   output logic                  out_psincdec,
   input  logic                  in_psdone,
   output logic [POS_WIDTH-1:0]  out_position,
   output logic                  out_busy,
   output logic                  out_done,
   output logic                  out_timeout,
   output logic [2:0]            out_state
);

   // Count must hold both the largest relative magnitude 2**(STEP_WIDTH-1)
   // and the largest absolute move of half a period.
   localparam int                   CNT_W    = (STEP_WIDTH > POS_WIDTH) ? STEP_WIDTH : POS_WIDTH;
   localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(STEPS_PER_PERIOD - 1);
   localparam logic [31:0]          SPP_U    = 32'(STEPS_PER_PERIOD);

   fineps_state_e         state, state_next;
   logic                  abs_q, abs_next;
   logic [STEP_WIDTH-1:0] value_q, value_next;
   logic                  dir_q, dir_next;
   logic [CNT_W-1:0]      count_q, count_next;
   logic [POS_WIDTH-1:0]  pos_q, pos_next;
   logic                  timeout_q, timeout_next;
   logic                  psen_q, done_q, busy_q, ready_q;

   logic                  wd_clr, wd_en, wd_expired;
   logic [STEP_WIDTH-1:0] rel_mag;
   logic [POS_WIDTH-1:0]  target;
   fineps_path_t          path;

   fineps_psdone_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (in_clk),
      .rst_n  (in_rst_n),
      .clr    (wd_clr),
      .en     (wd_en),
      .expired(wd_expired)
   );

   // Step-count datapath for CALC, derived from the latched command.
   always_comb begin
      rel_mag = value_q[STEP_WIDTH-1] ? (-value_q) : value_q;
      if (32'(value_q) >= SPP_U) begin
         target = POS_LAST;
      end else begin
         target = POS_WIDTH'(value_q);
      end
      path = fineps_shortest_path(32'(target), 32'(pos_q), SPP_U);
   end

   // Command handshake: a command transfers on a rising edge where
   // in_cmd_valid and out_cmd_ready are both high; the command fields must
   // be stable while in_cmd_valid is high. out_cmd_ready is registered and
   // only high in IDLE with the MMCM locked, so at most one command is in
   // flight and none is taken while lock is being lost.
   always_comb begin
      state_next   = state;
      abs_next     = abs_q;
      value_next   = value_q;
      dir_next     = dir_q;
      count_next   = count_q;
      pos_next     = pos_q;
      timeout_next = timeout_q;
      wd_clr       = 1'b0;
      wd_en        = 1'b0;

      if (!in_locked) begin
         // A relocked MMCM comes back at its static phase.
         state_next = ST_IDLE;
         pos_next   = '0;
         count_next = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_cmd_valid && ready_q) begin
                  abs_next     = in_cmd_abs;
                  value_next   = in_cmd_value;
                  timeout_next = 1'b0;
                  state_next   = ST_CALC;
               end
            end
            ST_CALC: begin
               if (abs_q) begin
                  dir_next   = path.inc;
                  count_next = CNT_W'(path.count);
               end else begin
                  dir_next   = ~value_q[STEP_WIDTH-1];
                  count_next = CNT_W'(rel_mag);
               end
               state_next = (count_next == '0) ? ST_FINISH : ST_ISSUE;
            end
            ST_ISSUE: begin
               wd_clr     = 1'b1;
               state_next = ST_WAIT;
            end
            ST_WAIT: begin
               wd_en = 1'b1;
               // PSDONE wins over expiry in the same cycle: the step did land.
               if (in_psdone) begin
                  if (dir_q) begin
                     pos_next = (pos_q == POS_LAST) ? '0 : (pos_q + POS_WIDTH'(1));
                  end else begin
                     pos_next = (pos_q == '0) ? POS_LAST : (pos_q - POS_WIDTH'(1));
                  end
                  count_next = count_q - CNT_W'(1);
                  state_next = (count_q == CNT_W'(1)) ? ST_FINISH : ST_ISSUE;
               end else if (wd_expired) begin
                  timeout_next = 1'b1;
                  count_next   = '0;
                  state_next   = ST_IDLE;
               end
            end
            ST_FINISH: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up exactly
   // with the state they describe.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state     <= ST_IDLE;
         abs_q     <= 1'b0;
         value_q   <= '0;
         dir_q     <= 1'b0;
         count_q   <= '0;
         pos_q     <= '0;
         timeout_q <= 1'b0;
         psen_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state     <= state_next;
         abs_q     <= abs_next;
         value_q   <= value_next;
         dir_q     <= dir_next;
         count_q   <= count_next;
         pos_q     <= pos_next;
         timeout_q <= timeout_next;
         psen_q    <= (state_next == ST_ISSUE);
         done_q    <= (state_next == ST_FINISH);
         busy_q    <= (state_next != ST_IDLE);
         ready_q   <= (state_next == ST_IDLE) && in_locked;
      end
   end

   assign out_cmd_ready = ready_q;
   assign out_psen      = psen_q;
   assign out_psincdec  = dir_q;
   assign out_position  = pos_q;
   assign out_busy      = busy_q;
   assign out_done      = done_q;
   assign out_timeout   = timeout_q;
   assign out_state     = state;

endmodule

// File: tb/tb_fineps_step_sequencer.sv
// tb_fineps_step_sequencer
// Directed bench for fineps_step_sequencer with an MMCM PSDONE responder,
// a PSEN monitor and an expected-step queue filled when each command is sent.
module tb_fineps_step_sequencer;
   import fineps_pkg::*;

   localparam int SPP = 504;

   logic        clk = 1'b0;
   logic        rst_n, locked, cmd_valid, cmd_abs;
   logic [11:0] cmd_value;
   logic        resp_psdone, stray_psdone;
   logic        psdone;
   logic        cmd_ready, psen, psincdec, busy, done, timeout;
   logic [8:0]  position;
   logic [2:0]  state;

   // Scoreboard entry per PSEN: {expected psincdec, expected position at PSEN}
   logic [9:0]  exp_q[$];

   int n_checks = 0, n_errors = 0;
   int done_cnt = 0, exp_done = 0, psen_cnt = 0;
   int cyc = 0, last_psen_cyc = 0;
   int answer_left = -1, psdone_delay = 12;
   bit rand_delay = 1'b0;
   int model_pos = 0;

   assign psdone = resp_psdone | stray_psdone;

   fineps_step_sequencer dut (
      .in_clk       (clk),
      .in_rst_n     (rst_n),
      .in_locked    (locked),
      .in_cmd_valid (cmd_valid),
      .out_cmd_ready(cmd_ready),
      .in_cmd_abs   (cmd_abs),
      .in_cmd_value (cmd_value),
      .out_psen     (psen),
      .out_psincdec (psincdec),
      .in_psdone    (psdone),
      .out_position (position),
      .out_busy     (busy),
      .out_done     (done),
      .out_timeout  (timeout),
      .out_state    (state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // ---------------- reference model: steps for a command ----------------
   task automatic push_expect(input bit abs_m, input int val);
      int t, d, n;
      bit inc;
      if (abs_m) begin
         t = val & 'hFFF;
         if (t >= SPP) t = SPP - 1;
         d = ((t - model_pos) % SPP + SPP) % SPP;
         if (d <= SPP / 2) begin
            inc = 1'b1; n = d;
         end else begin
            inc = 1'b0; n = SPP - d;
         end
      end else begin
         t = val & 'hFFF;
         if (t >= 2048) t = t - 4096;
         inc = (t >= 0);
         n = inc ? t : -t;
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({inc, 9'(model_pos)});
         model_pos = inc ? (model_pos + 1) % SPP : (model_pos + SPP - 1) % SPP;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input bit abs_m, input int val);
      int budget;
      budget = 0;
      while (cmd_ready !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      push_expect(abs_m, val);
      cmd_abs   = abs_m;
      cmd_value = 12'(val);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int budget;
      budget = 0;
      while (busy === 1'b1 && budget < limit) begin
         @(negedge clk);
         budget++;
      end
      check("busy_clears", busy, 0);
      @(negedge clk);
   endtask

   task automatic check_settled(input string tag);
      check({tag, "_position"}, position, model_pos);
      check({tag, "_sb_drained"}, exp_q.size(), 0);
      check({tag, "_done_count"}, done_cnt, exp_done);
      check({tag, "_no_timeout"}, timeout, 0);
   endtask

   task automatic run_cmd(input bit abs_m, input int val, input string tag, input int n_steps);
      int p0;
      p0 = psen_cnt;
      @(negedge clk);
      send_cmd(abs_m, val);
      exp_done++;
      wait_idle(20000);
      check_settled(tag);
      check({tag, "_psen_count"}, psen_cnt - p0, n_steps);
   endtask

   // ---------------- MMCM PSDONE responder ----------------
   initial begin
      int k;
      resp_psdone = 1'b0;
      forever begin
         @(negedge clk);
         if (psen === 1'b1 && answer_left != 0) begin
            if (answer_left > 0) answer_left--;
            k = rand_delay ? int'($urandom_range(1, 4)) : psdone_delay;
            repeat (k) @(posedge clk);
            #1 resp_psdone = 1'b1;
            @(posedge clk);
            #1 resp_psdone = 1'b0;
         end
      end
   end

   // ---------------- PSEN / done monitor ----------------
   initial begin
      logic [9:0] e;
      logic       psen_prev;
      psen_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (psen === 1'b1) begin
            psen_cnt++;
            last_psen_cyc = cyc;
            check("psen_one_cycle", psen_prev, 0);
            check("psen_has_expectation", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("psincdec", psincdec, e[9]);
               check("position_at_step", position, e[8:0]);
            end
         end
         psen_prev = psen;
      end
   end

   // ---------------- overall time bound ----------------
   initial begin
      #50_000_000;
      $display("FAIL global_timeout: simulation did not complete, %0d errors so far", n_errors);
      $fatal(1, "global time bound expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int p0, d0, start, budget;
      rst_n        = 1'b0;
      locked       = 1'b0;
      cmd_valid    = 1'b0;
      cmd_abs      = 1'b0;
      cmd_value    = '0;
      stray_psdone = 1'b0;

      // Reset with the MMCM unlocked
      repeat (3) @(negedge clk);
      check("rst_psen", psen, 0);
      check("rst_psincdec", psincdec, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_position", position, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_state", state, ST_IDLE);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("unlocked_ready", cmd_ready, 0);

      // Lock: ready one edge later
      locked = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_lock", cmd_ready, 1);

      // Stray PSDONE while idle
      @(negedge clk);
      stray_psdone = 1'b1;
      @(negedge clk);
      stray_psdone = 1'b0;
      @(negedge clk);
      check("idle_stray_position", position, 0);
      check("idle_stray_state", state, ST_IDLE);

      // Relative +5, PSDONE 12 cycles after PSEN, with latency checks
      p0 = psen_cnt;
      @(negedge clk);
      send_cmd(1'b0, 5);
      exp_done++;
      check("accept_busy", busy, 1);
      check("accept_state_calc", state, ST_CALC);
      check("accept_ready_low", cmd_ready, 0);
      @(posedge clk);
      #1;
      check("first_psen_latency", psen, 1);
      check("first_psen_dir", psincdec, 1);
      wait_idle(2000);
      check_settled("rel_plus5");
      check("rel_plus5_psen_count", psen_cnt - p0, 5);
      check("rel_plus5_position", position, 5);

      // Randomised PSDONE latency from here on
      rand_delay = 1'b1;
      run_cmd(1'b0, -4, "rel_minus4", 4);
      run_cmd(1'b0, -3, "rel_minus3_wrap", 3);
      check("wrap_position_502", position, 502);

      // Absolute moves from position 10
      run_cmd(1'b1, 10, "abs_to_10", 12);
      run_cmd(1'b1, 300, "abs_300_dec", 214);
      check("abs_300_position", position, 300);
      run_cmd(1'b1, 10, "abs_back_10", 214);
      run_cmd(1'b1, 262, "abs_262_tie", 252);
      check("abs_262_position", position, 262);
      run_cmd(1'b1, 10, "abs_10_tie", 252);
      run_cmd(1'b1, 600, "abs_600_sat", 11);
      check("abs_600_position", position, 503);

      // Zero-count command: done at accept+2, ready back right after
      @(negedge clk);
      send_cmd(1'b1, 503);
      exp_done++;
      check("zero_state_calc", state, ST_CALC);
      @(posedge clk);
      #1;
      check("zero_done_at_n2", done, 1);
      check("zero_no_psen", psen, 0);
      @(posedge clk);
      #1;
      check("zero_done_one_cycle", done, 0);
      check("zero_busy_low", busy, 0);
      check("zero_ready_back", cmd_ready, 1);
      @(negedge clk);
      check_settled("abs_zero");
      run_cmd(1'b0, 0, "rel_zero", 0);

      // Most negative relative value: 2048 decrements
      run_cmd(1'b0, -2048, "rel_most_negative", 2048);

      // Watchdog: PSDONE withheld on step 2 of +4
      rand_delay   = 1'b0;
      psdone_delay = 2;
      answer_left  = 1;
      p0           = psen_cnt;
      d0           = done_cnt;
      start        = model_pos;
      @(negedge clk);
      send_cmd(1'b0, 4);
      budget = 0;
      while (timeout !== 1'b1 && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      check("wd_timeout_set", timeout, 1);
      check("wd_latency", cyc - last_psen_cyc, 65);
      check("wd_busy_low", busy, 0);
      check("wd_state_idle", state, ST_IDLE);
      check("wd_position_one_step", position, (start + 1) % SPP);
      check("wd_psen_count", psen_cnt - p0, 2);
      check("wd_no_done", done_cnt, d0);
      exp_q.delete();
      model_pos   = (start + 1) % SPP;
      answer_left = -1;
      repeat (5) @(negedge clk);
      check("wd_timeout_sticky", timeout, 1);
      @(negedge clk);
      send_cmd(1'b0, 1);
      exp_done++;
      check("wd_cleared_on_accept", timeout, 0);
      wait_idle(200);
      check_settled("after_wd");

      // Lock loss mid-command, then stray PSDONE
      psdone_delay = 5;
      p0 = psen_cnt;
      @(negedge clk);
      send_cmd(1'b0, 20);
      budget = 0;
      while (psen_cnt - p0 < 3 && budget < 200) begin
         @(negedge clk);
         #1;
         budget++;
      end
      check("lock_progress", psen_cnt - p0, 3);
      @(negedge clk);
      locked = 1'b0;
      @(posedge clk);
      #1;
      check("lock_state_idle", state, ST_IDLE);
      check("lock_psen_low", psen, 0);
      check("lock_busy_low", busy, 0);
      check("lock_done_low", done, 0);
      check("lock_position_zero", position, 0);
      check("lock_ready_low", cmd_ready, 0);
      check("lock_timeout_holds", timeout, 0);
      exp_q.delete();
      model_pos = 0;
      repeat (20) @(negedge clk);
      stray_psdone = 1'b1;
      @(negedge clk);
      stray_psdone = 1'b0;
      @(negedge clk);
      check("lock_stray_position", position, 0);
      check("lock_stray_state", state, ST_IDLE);
      check("lock_no_done", done_cnt, exp_done);
      locked = 1'b1;
      @(posedge clk);
      #1;
      check("relock_ready", cmd_ready, 1);
      psdone_delay = 3;
      run_cmd(1'b0, 2, "after_relock", 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
